// File: rtl/fir_stream_pkg.sv
// rtl/fir_stream_pkg.sv - shared sample/accumulator types for the FIR stream path
package fir_stream_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [15:0]         acc_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - single-clock sample FIFO with stored head and separate occupancy counter
module fir_sync_fifo
  import fir_stream_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head comes from storage only, so a sample written this cycle is never visible to a same-cycle pop.
  assign dout = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - paces buffered upstream samples onto the FIR x input at a fixed rate
module fir_sample_feeder
  import fir_stream_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8,
  parameter int DIV    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    enable,
  output logic [DATA_W-1:0]       x_out,
  output logic                    x_strobe,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    underrun,
  input  logic                    clr_underrun
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]  divider;
  logic              tick;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  assign s_ready = !full;
  assign push    = s_valid && s_ready;
  assign tick    = enable && (divider == DIV_LAST);
  assign pop     = tick && !empty;

  fir_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  // Dropping enable restarts the period, so the first strobe after re-enable is a full period away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider <= '0;
    end else if (!enable || tick) begin
      divider <= '0;
    end else begin
      divider <= divider + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out    <= '0;
      x_strobe <= 1'b0;
    end else begin
      x_strobe <= tick;
      if (tick) x_out <= empty ? '0 : head;
    end
  end

  // A starved tick wins over a coincident clear so the event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (tick && empty) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - randomized and directed bench for fir_sample_feeder against a queue model
module tb_fir_sample_feeder;

  localparam int DIV_P [2] = '{4, 1};
  localparam int DEP_P [2] = '{8, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data   [2];
  logic       s_valid  [2];
  logic       enable   [2];
  logic       clr      [2];
  logic [7:0] x_out    [2];
  logic       s_ready  [2];
  logic       x_strobe [2];
  logic       underrun [2];
  logic [3:0] fill0;
  logic [1:0] fill1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq [2][$];
  int         run     [2];
  logic [7:0] ex_x    [2];
  bit         ex_strb [2];
  bit         ex_und  [2];
  bit         m_push  [2];
  logic [7:0] got0 [$];

  always #5 clk = ~clk;

  fir_sample_feeder #(.DATA_W(8), .DEPTH(8), .DIV(4)) u_dut0 (
    .clk(clk), .reset(reset), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .enable(enable[0]), .x_out(x_out[0]), .x_strobe(x_strobe[0]), .fill_level(fill0),
    .underrun(underrun[0]), .clr_underrun(clr[0])
  );

  fir_sample_feeder #(.DATA_W(8), .DEPTH(2), .DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .enable(enable[1]), .x_out(x_out[1]), .x_strobe(x_strobe[1]), .fill_level(fill1),
    .underrun(underrun[1]), .clr_underrun(clr[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fill_of(input int i);
    return (i == 0) ? 32'(fill0) : 32'(fill1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      run[i]     = 0;
      ex_x[i]    = 8'd0;
      ex_strb[i] = 1'b0;
      ex_und[i]  = 1'b0;
      m_push[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    bit pu, tk, emp;
    emp = (mq[i].size() == 0);
    pu  = s_valid[i] && (mq[i].size() < DEP_P[i]);
    tk  = enable[i] && ((run[i] % DIV_P[i]) == DIV_P[i] - 1);
    run[i] = enable[i] ? run[i] + 1 : 0;
    ex_strb[i] = tk;
    if (tk) begin
      if (emp) ex_x[i] = 8'd0;
      else     ex_x[i] = mq[i].pop_front();
    end
    if (tk && emp)  ex_und[i] = 1'b1;
    else if (clr[i]) ex_und[i] = 1'b0;
    if (pu) mq[i].push_back(s_data[i]);
    m_push[i] = pu;
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("d%0d_x_out", i),    32'(x_out[i]),    32'(ex_x[i]));
      check_eq($sformatf("d%0d_x_strobe", i), 32'(x_strobe[i]), 32'(ex_strb[i]));
      check_eq($sformatf("d%0d_fill", i),     fill_of(i),       32'(mq[i].size()));
      check_eq($sformatf("d%0d_underrun", i), 32'(underrun[i]), 32'(ex_und[i]));
      check_eq($sformatf("d%0d_s_ready", i),  32'(s_ready[i]),  32'(mq[i].size() != DEP_P[i]));
    end
    if (x_strobe[0]) got0.push_back(x_out[0]);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_d%0d_x_out", tag, i),    32'(x_out[i]),    32'd0);
      check_eq($sformatf("%s_d%0d_x_strobe", tag, i), 32'(x_strobe[i]), 32'd0);
      check_eq($sformatf("%s_d%0d_fill", tag, i),     fill_of(i),       32'd0);
      check_eq($sformatf("%s_d%0d_underrun", tag, i), 32'(underrun[i]), 32'd0);
    end
  endtask

  // Called just after a sample point; reset is raised and dropped between clock edges.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check_zero_outputs(tag);
    model_reset();
    #2 reset = 1'b0;
  endtask

  task automatic push0(input logic [7:0] v);
    s_valid[0] = 1'b1;
    s_data[0]  = v;
    step();
    s_valid[0] = 1'b0;
  endtask

  task automatic check_list(input string tag, input logic [7:0] exp [$]);
    check_eq({tag, "_count_ok"}, 32'(got0.size() >= exp.size()), 32'd1);
    for (int k = 0; k < exp.size() && k < got0.size(); k++)
      check_eq($sformatf("%s_%0d", tag, k), 32'(got0[k]), 32'(exp[k]));
  endtask

  initial begin
    logic [7:0] exp_l [$];
    bit accepted;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = 8'd0; s_valid[i] = 1'b0; enable[i] = 1'b0; clr[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;
    check_eq("reset_s_ready", 32'(s_ready[0]), 32'd1);

    // DUT1 runs its continuous-push scenario throughout the directed phase
    s_valid[1] = 1'b1; s_data[1] = 8'd7; enable[1] = 1'b1;

    // 1: buffered burst drained at the sample rate, then starvation
    push0(8'd10); push0(8'd20); push0(8'd30); push0(8'd0); push0(8'd5);
    got0.delete();
    enable[0] = 1'b1;
    repeat (24) step();
    exp_l = '{8'd10, 8'd20, 8'd30, 8'd0, 8'd5, 8'd0};
    check_list("t1_order", exp_l);
    check_eq("t1_underrun", 32'(underrun[0]), 32'd1);
    check_eq("t6_x_out", 32'(x_out[1]), 32'd7);
    check_eq("t6_strobe", 32'(x_strobe[1]), 32'd1);

    // 2: fill to full, hold a ninth sample against backpressure
    enable[0] = 1'b0;
    step();
    for (int v = 1; v <= 8; v++) push0(8'(v));
    check_eq("t2_fill_full", fill_of(0), 32'd8);
    check_eq("t2_ready_low", 32'(s_ready[0]), 32'd0);
    s_valid[0] = 1'b1; s_data[0] = 8'd9;
    step(); step();
    got0.delete();
    enable[0] = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 40 && !accepted; c++) begin
      step();
      accepted = m_push[0];
    end
    check_eq("t2_ninth_accepted", 32'(accepted), 32'd1);
    s_valid[0] = 1'b0;
    repeat (40) step();
    exp_l = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    check_list("t2_order", exp_l);

    // 3: clear alone, then clear coincident with a starved tick
    enable[0] = 1'b0;
    step();
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check_eq("t3_cleared", 32'(underrun[0]), 32'd0);
    clr[0] = 1'b1; enable[0] = 1'b1;
    repeat (4) step();
    check_eq("t3_set_wins", 32'(underrun[0]), 32'd1);
    clr[0] = 1'b0; enable[0] = 1'b0;
    step();

    // 4: asynchronous reset in mid-stream
    for (int v = 1; v <= 5; v++) push0(8'(v * 10));
    enable[0] = 1'b1;
    repeat (8) step();
    check_eq("t4_pre_x_out", 32'(x_out[0]), 32'd20);
    check_eq("t4_pre_fill", fill_of(0), 32'd3);
    async_reset("t4");
    check_eq("t4_ready_after", 32'(s_ready[0]), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq($sformatf("t4_strobe_c%0d", c), 32'(x_strobe[0]), 32'(c == 3));
    end

    // 5: enable gap between ticks restarts the period
    push0(8'd33); push0(8'd44);
    repeat (4) step();
    enable[0] = 1'b0;
    repeat (3) step();
    check_eq("t5_hold", 32'(x_out[0]), 32'(ex_x[0]));
    enable[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq($sformatf("t5_strobe_c%0d", c), 32'(x_strobe[0]), 32'(c == 3));
    end

    // Random traffic on both instances
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        s_valid[i] = ($urandom_range(0, 2) != 0);
        s_data[i]  = 8'($urandom);
        enable[i]  = ($urandom_range(0, 7) != 0);
        clr[i]     = ($urandom_range(0, 15) == 0);
      end
      step();
      if ($urandom_range(0, 299) == 0) async_reset("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
